pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the in-order core; replaces the fixed no-stall controller.
- Merges per-stage stall requests into the shared stall bus: bit 0 = PC, bit i+1 = stage i.
- Runs a small exception/ERET redirect FSM that drives a flush vector and a redirect PC, and keeps saturating stall and flush statistics counters.
- Sits beside the IF..WB stages; its outputs go to every stage register and to IF.

Parameters:
- NUM_STAGES, 5, number of pipeline stages (IF=0, ID=1, EX=2, MEM=3, WB=4).
- STALL_W, NUM_STAGES+1, width of the stall and flush buses.
- FLUSH_CYCLES, 1, cycles the flush is held after a redirect is accepted; legal range 1..15.
- EXC_VEC, 32'hBFC00380, exception handler entry PC.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stallreq  in  NUM_STAGES  bit i = stage i requests a stall.
- except_req  in  1  exception detected in MEM (one-cycle pulse).
- eret_req  in  1  ERET retiring in MEM (one-cycle pulse).
- epc_in  in  32  return PC for ERET; valid only while eret_req=1.
- clr_cnt  in  1  synchronously clears both statistics counters.
- stall  out  STALL_W  stall bus to PC and the stage registers.
- flush  out  STALL_W  flush bus; bit meaning is the same as stall.
- new_pc  out  32  redirect target for IF.
- new_pc_valid  out  1  IF loads new_pc on this cycle.
- busy  out  1  the redirect FSM is not IDLE.
- stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1.
- flush_count  out  CNT_W  saturating count of accepted redirects.

Behaviour:
- Stall (combinational):
  - k = highest index i with stallreq[i]=1; stall[j]=1 for j<=k+1, else 0.
  - Example: ID request -> 6'b000111. The receiving register inserts a bubble at stage k+1.
  - stall=0 when: no request, rst=1, or state is FLUSH.
- FSM states: IDLE, FLUSH.
  - In IDLE, the redirect is sampled at the clock edge.
  - except_req=1 -> go to FLUSH; new_pc<=EXC_VEC.
  - Otherwise eret_req=1 -> go to FLUSH; new_pc<=epc_in.
  - except_req has priority over eret_req when both are 1.
  - The accept edge loads hold_cnt<=FLUSH_CYCLES-1.
- FLUSH state:
  - flush=all ones and busy=1.
  - new_pc_valid=1 only in the first FLUSH cycle.
  - hold_cnt decrements each cycle; when hold_cnt=0, return to IDLE on the next edge.
  - FLUSH therefore lasts exactly FLUSH_CYCLES cycles.
  - except_req/eret_req arriving in FLUSH are ignored and not queued.
  - stallreq arriving in FLUSH is ignored.
- All FSM outputs (flush, new_pc_valid, busy, new_pc) are registered.
  - Latency from request to flush/new_pc_valid = 1 cycle.
  - In the request cycle, stall still follows stallreq.
- Counters:
  - stall_cycles increments on each edge where stall[0]=1.
  - flush_count increments on each accepted redirect.
  - Both saturate at all ones, with no wrap.
  - clr_cnt=1 clears both to 0 and wins over a same-cycle increment.
- Reset (rst=1, synchronous):
  - state=IDLE; flush=0, new_pc=0, new_pc_valid=0, busy=0, hold_cnt=0, both counters 0.
  - A reset asserted mid-FLUSH aborts the flush on the next edge, with no residual new_pc_valid.
- Width rules:
  - stall and flush widths track STALL_W.
  - hold_cnt is 4 bits.
  - Counter increments are unsigned.

Test Plan:
- Stall merge:
  - stallreq=5'b00010 -> stall=6'b000111.
  - stallreq=5'b01010 -> stall=6'b011111.
  - stallreq=0 -> stall=0; stall_cycles advances only on nonzero cycles.
- Exception, FLUSH_CYCLES=1:
  - except_req pulse at cycle 10 -> cycle 11: flush=6'b111111, new_pc=32'hBFC00380, new_pc_valid=1, busy=1.
  - Cycle 12: all 0; flush_count=1.
- ERET, simultaneous requests and hold:
  - eret_req with epc_in=32'h8000_1234 -> new_pc=32'h80001234 next cycle.
  - except_req and eret_req together -> new_pc=EXC_VEC.
  - FLUSH_CYCLES=3 -> flush high for 3 cycles, new_pc_valid for the first only.
  - A second except_req during FLUSH is ignored; flush_count increments by 1 only.
- Stall during flush: stallreq=5'b11111 held through FLUSH -> stall=0 while busy=1, then 6'b111111 once back in IDLE.
- Saturation and clear:
  - CNT_W=4 with 20 stalled cycles -> stall_cycles=4'hF, with no wrap.
  - clr_cnt with a stall present on the same edge -> 0.
- Reset mid-FLUSH: FLUSH_CYCLES=4, rst at the second FLUSH cycle -> the next edge gives busy=0, flush=0, new_pc=0, and counters 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall-bus merge, exception/ERET redirect FSM
// and saturating stall/flush statistics counters.
module pipe_ctrl #(
  parameter int          NUM_STAGES   = 5,
  parameter int          STALL_W      = NUM_STAGES + 1,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VEC      = 32'hBFC00380,
  parameter int          CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  except_req,
  input  logic                  eret_req,
  input  logic [31:0]           epc_in,
  input  logic                  clr_cnt,
  output logic [STALL_W-1:0]    stall,
  output logic [STALL_W-1:0]    flush,
  output logic [31:0]           new_pc,
  output logic                  new_pc_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_CYCLES - 1);

  state_t             state;
  state_t             state_nx;
  logic [3:0]         hold_cnt;
  logic [3:0]         hold_nx;
  logic [31:0]        pc_nx;
  logic               accept;
  logic [STALL_W-1:0] flush_nx;
  logic               busy_nx;

  // Stall every stage at or upstream of the oldest requester's successor
  always_comb begin
    stall = '0;
    if (!rst && state == IDLE) begin
      for (int j = 0; j < STALL_W; j++) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (stallreq[i] && (i + 1 >= j)) stall[j] = 1'b1;
        end
      end
    end
  end

  // Redirect FSM next state, hold counter and registered-output values
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    pc_nx    = new_pc;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (except_req) begin
          accept = 1'b1;
          pc_nx  = EXC_VEC;
        end else if (eret_req) begin
          accept = 1'b1;
          pc_nx  = epc_in;
        end
        if (accept) begin
          state_nx = FLUSH;
          hold_nx  = HOLD_INIT;
        end
      end
      FLUSH: begin
        if (hold_cnt == 4'd0) state_nx = IDLE;
        else hold_nx = hold_cnt - 4'd1;
      end
    endcase
    busy_nx  = (state_nx == FLUSH);
    flush_nx = busy_nx ? '1 : '0;
  end

  // FSM state and registered redirect outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= 4'd0;
      new_pc       <= 32'd0;
      new_pc_valid <= 1'b0;
      busy         <= 1'b0;
      flush        <= '0;
    end else begin
      state        <= state_nx;
      hold_cnt     <= hold_nx;
      new_pc       <= pc_nx;
      new_pc_valid <= accept;
      busy         <= busy_nx;
      flush        <= flush_nx;
    end
  end

  // Saturating statistics; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall[0] && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (accept && !(&flush_count))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: three parameterisations share
// one stimulus stream; expectations flow through a scoreboard queue.
module tb_pipe_ctrl;

  localparam logic [31:0] EXC = 32'hBFC00380;
  localparam int F_STALL = 0;
  localparam int F_FLUSH = 1;
  localparam int F_PC    = 2;
  localparam int F_NPV   = 3;
  localparam int F_BUSY  = 4;
  localparam int F_SC    = 5;
  localparam int F_FC    = 6;

  typedef struct {
    string       name;
    int          dut;
    int          fld;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  stallreq;
  logic        except_req;
  logic        eret_req;
  logic [31:0] epc_in;
  logic        clr_cnt;

  logic [5:0]  st_a, fl_a, st_b, fl_b, st_c, fl_c;
  logic [31:0] pc_a, pc_b, pc_c;
  logic        npv_a, npv_b, npv_c;
  logic        bz_a, bz_b, bz_c;
  logic [31:0] sc_a, fc_a, sc_c, fc_c;
  logic [3:0]  sc_b, fc_b;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] got;
  int          vectors;
  int          miscompares;

  pipe_ctrl u_a (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .except_req(except_req), .eret_req(eret_req),
    .epc_in(epc_in), .clr_cnt(clr_cnt),
    .stall(st_a), .flush(fl_a), .new_pc(pc_a),
    .new_pc_valid(npv_a), .busy(bz_a),
    .stall_cycles(sc_a), .flush_count(fc_a)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .except_req(except_req), .eret_req(eret_req),
    .epc_in(epc_in), .clr_cnt(clr_cnt),
    .stall(st_b), .flush(fl_b), .new_pc(pc_b),
    .new_pc_valid(npv_b), .busy(bz_b),
    .stall_cycles(sc_b), .flush_count(fc_b)
  );

  pipe_ctrl #(.FLUSH_CYCLES(4)) u_c (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .except_req(except_req), .eret_req(eret_req),
    .epc_in(epc_in), .clr_cnt(clr_cnt),
    .stall(st_c), .flush(fl_c), .new_pc(pc_c),
    .new_pc_valid(npv_c), .busy(bz_c),
    .stall_cycles(sc_c), .flush_count(fc_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] obs(int d, int f);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    case (d)
      0: case (f)
        F_STALL: r = {26'd0, st_a};
        F_FLUSH: r = {26'd0, fl_a};
        F_PC:    r = pc_a;
        F_NPV:   r = {31'd0, npv_a};
        F_BUSY:  r = {31'd0, bz_a};
        F_SC:    r = sc_a;
        F_FC:    r = fc_a;
        default: r = 32'hDEAD_BEEF;
      endcase
      1: case (f)
        F_STALL: r = {26'd0, st_b};
        F_FLUSH: r = {26'd0, fl_b};
        F_PC:    r = pc_b;
        F_NPV:   r = {31'd0, npv_b};
        F_BUSY:  r = {31'd0, bz_b};
        F_SC:    r = {28'd0, sc_b};
        F_FC:    r = {28'd0, fc_b};
        default: r = 32'hDEAD_BEEF;
      endcase
      default: case (f)
        F_STALL: r = {26'd0, st_c};
        F_FLUSH: r = {26'd0, fl_c};
        F_PC:    r = pc_c;
        F_NPV:   r = {31'd0, npv_c};
        F_BUSY:  r = {31'd0, bz_c};
        F_SC:    r = sc_c;
        F_FC:    r = fc_c;
        default: r = 32'hDEAD_BEEF;
      endcase
    endcase
    return r;
  endfunction

  task automatic push(string n, int d, int f, logic [31:0] v);
    exp_t x;
    x.name = n;
    x.dut  = d;
    x.fld  = f;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stallreq = 5'b11111;
    tick(2);
    push("rst_stall", 0, F_STALL, 32'h0);
    push("rst_flush", 0, F_FLUSH, 32'h0);
    push("rst_pc", 0, F_PC, 32'h0);
    push("rst_npv", 0, F_NPV, 32'h0);
    push("rst_busy", 0, F_BUSY, 32'h0);
    push("rst_sc", 0, F_SC, 32'h0);
    push("rst_fc", 0, F_FC, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    rst = 1'b0;
    stallreq = 5'b0;
    tick();
  endtask

  task automatic test_stall_merge();
    logic [4:0] pats[6];
    int nz;
    int k;
    pats[0] = 5'b00010;
    pats[1] = 5'b01010;
    pats[2] = 5'b00000;
    pats[3] = 5'b00001;
    pats[4] = 5'b10000;
    pats[5] = 5'b00100;
    nz = 0;
    clear_counters();
    for (int p = 0; p < 6; p++) begin
      stallreq = pats[p];
      k = -1;
      for (int i = 4; i >= 0; i--) begin
        if (k < 0 && pats[p][i]) k = i;
      end
      if (k >= 0) nz++;
      push("stall_merge", 0, F_STALL,
           (k < 0) ? 32'h0 : ((32'h1 << (k + 2)) - 32'h1));
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = obs(e.dut, e.fld);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s[%0d]: got %h want %h", e.name, p, got, e.val);
        end
      end
      tick();
    end
    stallreq = 5'b0;
    push("stall_cycles", 0, F_SC, 32'(nz));
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
  endtask

  task automatic test_exception();
    clear_counters();
    stallreq = 5'b00010;
    except_req = 1'b1;
    push("req_cycle_stall", 0, F_STALL, 32'h07);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    push("exc_flush", 0, F_FLUSH, 32'h3F);
    push("exc_pc", 0, F_PC, EXC);
    push("exc_npv", 0, F_NPV, 32'h1);
    push("exc_busy", 0, F_BUSY, 32'h1);
    tick();
    except_req = 1'b0;
    stallreq = 5'b0;
    push("exc_done_flush", 0, F_FLUSH, 32'h0);
    push("exc_done_npv", 0, F_NPV, 32'h0);
    push("exc_done_busy", 0, F_BUSY, 32'h0);
    push("exc_fc", 0, F_FC, 32'h1);
    for (int c = 0; c < 2; c++) begin
      while (c == 1 && sb.size() > 0) begin
        e = sb.pop_front();
        got = obs(e.dut, e.fld);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s: got %h want %h", e.name, got, e.val);
        end
      end
      while (c == 0 && sb.size() > 4) begin
        e = sb.pop_front();
        got = obs(e.dut, e.fld);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s: got %h want %h", e.name, got, e.val);
        end
      end
      if (c == 0) tick();
    end
    tick(5);
  endtask

  task automatic test_eret();
    eret_req = 1'b1;
    epc_in = 32'h8000_1234;
    push("eret_pc", 0, F_PC, 32'h8000_1234);
    push("eret_npv", 0, F_NPV, 32'h1);
    tick();
    eret_req = 1'b0;
    epc_in = 32'h0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    tick(5);
    except_req = 1'b1;
    eret_req = 1'b1;
    epc_in = 32'h1234_5678;
    push("both_pc", 0, F_PC, EXC);
    push("both_npv", 0, F_NPV, 32'h1);
    tick();
    except_req = 1'b0;
    eret_req = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    tick(5);
  endtask

  task automatic test_hold();
    clear_counters();
    except_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      push("hold_flush", 1, F_FLUSH, (c <= 3) ? 32'h3F : 32'h0);
      push("hold_npv", 1, F_NPV, (c == 1) ? 32'h1 : 32'h0);
      push("hold_busy", 1, F_BUSY, (c <= 3) ? 32'h1 : 32'h0);
      tick();
      except_req = (c == 1);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = obs(e.dut, e.fld);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s[c%0d]: got %h want %h", e.name, c, got, e.val);
        end
      end
    end
    push("hold_fc", 1, F_FC, 32'h1);
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    tick(4);
  endtask

  task automatic test_stall_in_flush();
    stallreq = 5'b11111;
    except_req = 1'b1;
    push("sif_req_stall", 1, F_STALL, 32'h3F);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    for (int c = 1; c <= 4; c++) begin
      push("sif_stall", 1, F_STALL, (c <= 3) ? 32'h0 : 32'h3F);
      push("sif_busy", 1, F_BUSY, (c <= 3) ? 32'h1 : 32'h0);
      tick();
      except_req = 1'b0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = obs(e.dut, e.fld);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s[c%0d]: got %h want %h", e.name, c, got, e.val);
        end
      end
    end
    stallreq = 5'b0;
    tick(5);
  endtask

  task automatic test_saturation();
    clear_counters();
    stallreq = 5'b00001;
    for (int c = 1; c <= 20; c++) begin
      if (c == 15 || c == 20)
        push("sat_sc", 1, F_SC, 32'hF);
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = obs(e.dut, e.fld);
        vectors++;
        if (got !== e.val) begin
          miscompares++;
          $display("FAIL %s[c%0d]: got %h want %h", e.name, c, got, e.val);
        end
      end
    end
    clr_cnt = 1'b1;
    push("clr_sc_b", 1, F_SC, 32'h0);
    push("clr_fc_b", 1, F_FC, 32'h0);
    push("clr_sc_a", 0, F_SC, 32'h0);
    tick();
    clr_cnt = 1'b0;
    stallreq = 5'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    tick(2);
  endtask

  task automatic test_reset_mid_flush();
    stallreq = 5'b00100;
    tick(3);
    stallreq = 5'b0;
    except_req = 1'b1;
    push("rmf_busy1", 2, F_BUSY, 32'h1);
    push("rmf_npv1", 2, F_NPV, 32'h1);
    tick();
    except_req = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    push("rmf_busy2", 2, F_BUSY, 32'h1);
    push("rmf_npv2", 2, F_NPV, 32'h0);
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    rst = 1'b1;
    push("rmf_busy", 2, F_BUSY, 32'h0);
    push("rmf_flush", 2, F_FLUSH, 32'h0);
    push("rmf_pc", 2, F_PC, 32'h0);
    push("rmf_npv", 2, F_NPV, 32'h0);
    push("rmf_sc", 2, F_SC, 32'h0);
    push("rmf_fc", 2, F_FC, 32'h0);
    tick();
    rst = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
    push("rmf_post_npv", 2, F_NPV, 32'h0);
    push("rmf_post_busy", 2, F_BUSY, 32'h0);
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.dut, e.fld);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, got, e.val);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    stallreq = 5'b0;
    except_req = 1'b0;
    eret_req = 1'b0;
    epc_in = 32'h0;
    clr_cnt = 1'b0;
    test_reset();
    test_stall_merge();
    test_exception();
    test_eret();
    test_hold();
    test_stall_in_flush();
    test_saturation();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
